key_entry_decoder: RTL and testbench
====================================

# key_entry_decoder

Consumes the one-pulse-per-press eBCD key stream from `keypad_driver` and assembles it into calculator operands. Builds a signed decimal entry buffer, latches `operand1`, `operator` and `operand2`, and issues a one-cycle `calc_start` strobe to `calculate`. Also supplies `fnd_serial` to `segment_driver`, showing either the number being typed or the returned result.

## Interface
- `MAX_DIGITS`, 9: maximum significant digits per operand; 9 keeps magnitude < 2^31.
- `sw_clk` in 1: key-scan clock (2^-21 of `clock_50m`); all logic on posedge.
- `rst` in 1: reset, asynchronous, active-low.
- `key_valid` in 1: one-cycle strobe; `eBCD` is valid in that cycle.
- `eBCD` in 4: key code; 0–9 digit, A `+`, B `-`, C `*`, D `/`, E `=`, F clear.
- `result` in 32 signed: `calculate` output, sampled in S_RES.
- `operand1` out 32 signed: first operand.
- `operand2` out 32 signed: second operand.
- `operator` out 3: 0 add, 1 sub, 2 mul, 3 div.
- `calc_start` out 1: one-cycle strobe; operands and operator are stable while it is high.
- `fnd_serial` out 32 signed: display value.
- `entry_err` out 1: digit-overflow flag (see Configuration).

## Operation
- State: `signBit`, 31-bit `buffer`, digit counter `cnt` (0..MAX_DIGITS).
- Digit accumulate: `buffer <= buffer*10 + d`.
  - Zero into an empty buffer leaves `cnt` at 0.
  - Any other digit increments `cnt`.
  - At `cnt==MAX_DIGITS` the digit is dropped.
- Signed value is `signBit ? -buffer : buffer`.
- S_OP1 (reset state):
  - Digit: accumulate.
  - `-` with `cnt==0`: toggle `signBit`.
  - `+`, `*`, `/`, or `-` with `cnt>0`: `operand1` <= signed value, set `operator`, clear buffer/sign/cnt, go to S_OPR.
  - `=`: ignored.
- S_OPR:
  - Digit: `buffer=d`, `cnt` per the rule above, go to S_OP2.
  - `-`: toggle `signBit` (sign of operand2).
  - `+`, `*`, `/`: replace `operator`.
  - `=`: ignored.
- S_OP2:
  - Digit: accumulate.
  - `-` with `cnt==0`: toggle sign.
  - Other operator keys: ignored.
  - `=`: `operand2` <= signed value, pulse `calc_start`, go to S_RES.
- S_RES:
  - Digit: clear, `buffer=d`, go to S_OP1.
  - Operator key: `operand1 <= result`, set `operator`, clear buffer, go to S_OPR (chaining).
  - `=`: ignored.
- `F` in any state: all registers to reset values, go to S_OP1.
- Display (`fnd_serial`):
  - S_OP1, S_OP2: signed buffer.
  - S_OPR: `operand1`, or `-0` shown as 0 if sign is toggled with an empty buffer.
  - S_RES: `result`.

## Timing
- All outputs registered.
- Reset values: `operand1=0`, `operand2=0`, `operator=0`, `calc_start=0`, `fnd_serial=0`, `entry_err=0`, state S_OP1.
- A key sampled at edge N is reflected in state and outputs after edge N; latency is 1 cycle.
- `calc_start` is high for exactly the cycle after the `=` edge. `operand2` updates on the same edge.
- Every cycle with `key_valid` high is a separate press. Back-to-back presses are fully supported.
- `eBCD` is ignored when `key_valid` is low.
- Asserting `rst` mid-operation clears everything immediately, including an in-flight `calc_start`.
- `result` is sampled combinationally into the display and registered on chaining. `calculate` has settled by the next key press.

## Configuration
- `ENTRY_OVF_ERR_EN` defined:
  - A digit at `cnt==MAX_DIGITS` sets `entry_err`.
  - `entry_err` is sticky until `F` or reset; the digit is dropped.
  - While `entry_err=1`, `fnd_serial` is forced to 0x80000000 (error marker for `segment_driver`).
- Undefined: overflow digits are silently dropped and `entry_err` is constant 0.

## Structure
- `calc_pkg` holds:
  - eBCD key codes (`KEY_ADD`…`KEY_CLR`).
  - Operator encodings.
  - State encoding S_OP1/S_OPR/S_OP2/S_RES.
  - Default `MAX_DIGITS`.
- `calculate` includes the same package.
- One sub-module, `bcd_accum`: combinational `buffer*10+d` via `(b<<3)+(b<<1)+d`, plus the cnt/limit logic.

## Test plan
- Keys 1,2,3,`+`,4,5,`=` → `operand1=123`, `operand2=45`, `operator=0`, one `calc_start` pulse; `fnd_serial` shows `result`.
- Keys `-`,7,`*`,`-`,3,`=` → `operand1=-7`, `operator=2`, `operand2=-3`.
- Keys 0,0,5 → `fnd_serial=5`, `cnt=1`. Then ten 9s → buffer 599999999. With the macro, `entry_err=1` and `fnd_serial=0x80000000`; `F` clears both.
- After `=` with `result=168`, keys `/`,2,`=` → `operand1=168`, `operator=3`, `operand2=2`.
- `rst` low during the `calc_start` cycle → `calc_start=0` immediately, all outputs 0, state S_OP1.
- In S_OPR, `+` then `*` → `operator=2`; no `calc_start`; `=` ignored.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared calculator definitions: eBCD key codes, operator and FSM encodings,
// default digit limit and small value helpers.
package calc_pkg;

    localparam int unsigned MAX_DIGITS_DEF = 9;
    localparam int unsigned CNT_W          = 4;

    localparam logic [3:0] KEY_ADD = 4'hA;
    localparam logic [3:0] KEY_SUB = 4'hB;
    localparam logic [3:0] KEY_MUL = 4'hC;
    localparam logic [3:0] KEY_DIV = 4'hD;
    localparam logic [3:0] KEY_EQ  = 4'hE;
    localparam logic [3:0] KEY_CLR = 4'hF;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_MUL = 3'd2,
        OP_DIV = 3'd3
    } op_t;

    typedef enum logic [1:0] {
        S_OP1,
        S_OPR,
        S_OP2,
        S_RES
    } state_t;

    function automatic logic is_digit(input logic [3:0] key);
        return key <= 4'd9;
    endfunction

    function automatic op_t key_to_op(input logic [3:0] key);
        case (key)
            KEY_SUB: return OP_SUB;
            KEY_MUL: return OP_MUL;
            KEY_DIV: return OP_DIV;
            default: return OP_ADD;
        endcase
    endfunction

    function automatic logic signed [31:0] apply_sign(input logic neg, input logic [30:0] mag);
        logic signed [31:0] v;
        v = signed'({1'b0, mag});
        return neg ? -v : v;
    endfunction

endpackage

// File: rtl/bcd_accum.sv
// Decimal digit accumulator: buffer*10+d with significant-digit counting;
// digits arriving once the limit is reached leave buffer and count unchanged.
module bcd_accum
    import calc_pkg::*;
#(
    parameter int unsigned MAX_DIGITS = MAX_DIGITS_DEF
) (
    input  logic [30:0]      buffer,
    input  logic [CNT_W-1:0] cnt,
    input  logic [3:0]       digit,
    output logic [30:0]      buffer_next,
    output logic [CNT_W-1:0] cnt_next
);

    always_comb begin
        buffer_next = buffer;
        cnt_next    = cnt;
        if (cnt != CNT_W'(MAX_DIGITS)) begin
            buffer_next = (buffer << 3) + (buffer << 1) + 31'(digit);
            // leading zeros are not significant, so an empty buffer stays at count 0
            if (cnt != '0 || digit != '0) begin
                cnt_next = cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/key_entry_decoder.sv
// Turns eBCD key presses into operand1/operator/operand2 plus a calc_start strobe
// and drives the display value. Optional: ENTRY_OVF_ERR_EN enables the sticky overflow flag.
module key_entry_decoder
    import calc_pkg::*;
#(
    parameter int unsigned MAX_DIGITS = MAX_DIGITS_DEF
) (
    input  logic               sw_clk,
    input  logic               rst,
    input  logic               key_valid,
    input  logic [3:0]         eBCD,
    input  logic signed [31:0] result,
    output logic signed [31:0] operand1,
    output logic signed [31:0] operand2,
    output logic [2:0]         operator,
    output logic               calc_start,
    output logic signed [31:0] fnd_serial,
    output logic               entry_err
);

    state_t             state, state_n;
    logic               sign_bit, sign_n;
    logic [30:0]        buffer, buffer_n, acc_buf;
    logic [CNT_W-1:0]   cnt, cnt_n, acc_cnt;
    logic signed [31:0] op1_n, op2_n, fnd_n, entry_val;
    logic [2:0]         op_n;
    logic               start_n, err_n;

    bcd_accum #(.MAX_DIGITS(MAX_DIGITS)) u_accum (
        .buffer     (buffer),
        .cnt        (cnt),
        .digit      (eBCD),
        .buffer_next(acc_buf),
        .cnt_next   (acc_cnt)
    );

    assign entry_val = apply_sign(sign_bit, buffer);

    always_comb begin
        state_n  = state;
        sign_n   = sign_bit;
        buffer_n = buffer;
        cnt_n    = cnt;
        op1_n    = operand1;
        op2_n    = operand2;
        op_n     = operator;
        err_n    = entry_err;
        start_n  = 1'b0;

        if (key_valid) begin
            if (eBCD == KEY_CLR) begin
                state_n  = S_OP1;
                sign_n   = 1'b0;
                buffer_n = '0;
                cnt_n    = '0;
                op1_n    = '0;
                op2_n    = '0;
                op_n     = '0;
                err_n    = 1'b0;
            end else if (is_digit(eBCD)) begin
                // buffer is already empty in S_OPR/S_RES, so accumulating equals loading d
                buffer_n = acc_buf;
                cnt_n    = acc_cnt;
                case (state)
                    S_OPR:   state_n = S_OP2;
                    S_RES: begin
                        sign_n  = 1'b0;
                        state_n = S_OP1;
                    end
                    default: ;
                endcase
`ifdef ENTRY_OVF_ERR_EN
                if (cnt == CNT_W'(MAX_DIGITS)) begin
                    err_n = 1'b1;
                end
`endif
            end else if (eBCD == KEY_EQ) begin
                if (state == S_OP2) begin
                    op2_n    = entry_val;
                    start_n  = 1'b1;
                    sign_n   = 1'b0;
                    buffer_n = '0;
                    cnt_n    = '0;
                    state_n  = S_RES;
                end
            end else begin
                case (state)
                    S_OP1: begin
                        if (eBCD == KEY_SUB && cnt == '0) begin
                            sign_n = ~sign_bit;
                        end else begin
                            op1_n    = entry_val;
                            op_n     = key_to_op(eBCD);
                            sign_n   = 1'b0;
                            buffer_n = '0;
                            cnt_n    = '0;
                            state_n  = S_OPR;
                        end
                    end
                    S_OPR: begin
                        if (eBCD == KEY_SUB) sign_n = ~sign_bit;
                        else                 op_n   = key_to_op(eBCD);
                    end
                    S_OP2: begin
                        if (eBCD == KEY_SUB && cnt == '0) sign_n = ~sign_bit;
                    end
                    default: begin
                        op1_n    = result;
                        op_n     = key_to_op(eBCD);
                        sign_n   = 1'b0;
                        buffer_n = '0;
                        cnt_n    = '0;
                        state_n  = S_OPR;
                    end
                endcase
            end
        end

        case (state_n)
            S_OP1, S_OP2: fnd_n = apply_sign(sign_n, buffer_n);
            S_OPR:        fnd_n = sign_n ? '0 : op1_n;
            default:      fnd_n = result;
        endcase
`ifdef ENTRY_OVF_ERR_EN
        if (err_n) fnd_n = 32'sh8000_0000;
`endif
    end

    always_ff @(posedge sw_clk or negedge rst) begin
        if (!rst) begin
            state      <= S_OP1;
            sign_bit   <= 1'b0;
            buffer     <= '0;
            cnt        <= '0;
            operand1   <= '0;
            operand2   <= '0;
            operator   <= '0;
            calc_start <= 1'b0;
            fnd_serial <= '0;
            entry_err  <= 1'b0;
        end else begin
            state      <= state_n;
            sign_bit   <= sign_n;
            buffer     <= buffer_n;
            cnt        <= cnt_n;
            operand1   <= op1_n;
            operand2   <= op2_n;
            operator   <= op_n;
            calc_start <= start_n;
            fnd_serial <= fnd_n;
            entry_err  <= err_n;
        end
    end

endmodule

// File: tb/tb_key_entry_decoder.sv
// Self-checking bench for key_entry_decoder: directed key sequences plus random
// presses, compared every cycle against a phase/magnitude reference model.
module tb_key_entry_decoder;

    localparam int MAXD = 9;
    localparam int PH_FIRST = 0, PH_OPER = 1, PH_SECOND = 2, PH_RESULT = 3;

    logic               sw_clk = 1'b0;
    logic               rst;
    logic               key_valid;
    logic [3:0]         eBCD;
    logic signed [31:0] result;
    logic signed [31:0] operand1, operand2, fnd_serial;
    logic [2:0]         operator;
    logic               calc_start, entry_err;

    int errors = 0;
    int checks = 0;

    int     phase;
    longint mag;
    bit     neg;
    int     m_op1, m_op2, m_op, m_fnd;
    bit     m_start, m_err;

    key_entry_decoder #(.MAX_DIGITS(MAXD)) dut (
        .sw_clk    (sw_clk),
        .rst       (rst),
        .key_valid (key_valid),
        .eBCD      (eBCD),
        .result    (result),
        .operand1  (operand1),
        .operand2  (operand2),
        .operator  (operator),
        .calc_start(calc_start),
        .fnd_serial(fnd_serial),
        .entry_err (entry_err)
    );

    always #5 sw_clk = ~sw_clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int digits_of(input longint v);
        int n = 0;
        while (v > 0) begin
            v = v / 10;
            n++;
        end
        return n;
    endfunction

    function automatic int entry_value();
        return neg ? -int'(mag) : int'(mag);
    endfunction

    // What the downstream calculator would return for the latched operands
    function automatic int calc_model();
        case (m_op)
            0: return m_op1 + m_op2;
            1: return m_op1 - m_op2;
            2: return m_op1 * m_op2;
            default: begin
                if (m_op2 == 0)  return 0;
                if (m_op2 == -1) return -m_op1;
                return m_op1 / m_op2;
            end
        endcase
    endfunction

    task automatic model_reset();
        phase = PH_FIRST; mag = 0; neg = 0;
        m_op1 = 0; m_op2 = 0; m_op = 0; m_fnd = 0; m_start = 0; m_err = 0;
    endtask

    task automatic model_step(input bit v, input int k, input int res);
        m_start = 0;
        if (v) begin
            if (k == 15) begin
                model_reset();
            end else if (k <= 9) begin
                if (phase == PH_RESULT) begin
                    mag = 0; neg = 0; phase = PH_FIRST;
                end else if (phase == PH_OPER) begin
                    phase = PH_SECOND;
                end
                if (digits_of(mag) < MAXD) mag = mag * 10 + k;
`ifdef ENTRY_OVF_ERR_EN
                else m_err = 1;
`endif
            end else if (k == 14) begin
                if (phase == PH_SECOND) begin
                    m_op2 = entry_value(); m_start = 1;
                    mag = 0; neg = 0; phase = PH_RESULT;
                end
            end else begin
                case (phase)
                    PH_FIRST: begin
                        if (k == 11 && mag == 0) neg = !neg;
                        else begin
                            m_op1 = entry_value(); m_op = k - 10;
                            mag = 0; neg = 0; phase = PH_OPER;
                        end
                    end
                    PH_OPER: begin
                        if (k == 11) neg = !neg;
                        else m_op = k - 10;
                    end
                    PH_SECOND: if (k == 11 && mag == 0) neg = !neg;
                    default: begin
                        m_op1 = res; m_op = k - 10;
                        mag = 0; neg = 0; phase = PH_OPER;
                    end
                endcase
            end
        end
        case (phase)
            PH_FIRST, PH_SECOND: m_fnd = entry_value();
            PH_OPER:             m_fnd = neg ? 0 : m_op1;
            default:             m_fnd = res;
        endcase
        if (m_err) m_fnd = int'(32'h8000_0000);
    endtask

    task automatic compare_all();
        check_eq("operand1",   operand1,            m_op1);
        check_eq("operand2",   operand2,            m_op2);
        check_eq("operator",   {29'd0, operator},   m_op);
        check_eq("calc_start", {31'd0, calc_start}, {31'd0, m_start});
        check_eq("fnd_serial", fnd_serial,          m_fnd);
        check_eq("entry_err",  {31'd0, entry_err},  {31'd0, m_err});
    endtask

    // Called #1 after a posedge; applies one cycle of input and checks after the next edge
    task automatic press(input bit v, input logic [3:0] k);
        key_valid = v;
        eBCD      = k;
        result    = calc_model();
        @(posedge sw_clk);
        model_step(v, int'(k), result);
        #1;
        compare_all();
        key_valid = 1'b0;
    endtask

    task automatic press_seq(input logic [3:0] keys[$]);
        foreach (keys[i]) press(1'b1, keys[i]);
    endtask

    initial begin
        rst = 1'b0; key_valid = 1'b0; eBCD = 4'h0; result = '0;
        model_reset();
        repeat (2) @(posedge sw_clk);
        #1;
        check_eq("rst_op1",   operand1,            0);
        check_eq("rst_op2",   operand2,            0);
        check_eq("rst_oper",  {29'd0, operator},   0);
        check_eq("rst_start", {31'd0, calc_start}, 0);
        check_eq("rst_fnd",   fnd_serial,          0);
        check_eq("rst_err",   {31'd0, entry_err},  0);
        rst = 1'b1;
        @(posedge sw_clk); #1;

        // 123 + 45 =
        press_seq('{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'hE});
        check_eq("t1_op1",   operand1,            123);
        check_eq("t1_op2",   operand2,            45);
        check_eq("t1_start", {31'd0, calc_start}, 1);
        press(1'b0, 4'h0);
        check_eq("t1_pulse", {31'd0, calc_start}, 0);
        check_eq("t1_fnd",   fnd_serial,          168);

        // -7 * -3 =
        press_seq('{4'hF, 4'hB, 4'h7, 4'hC, 4'hB, 4'h3, 4'hE});
        check_eq("t2_op1",  operand1,          -7);
        check_eq("t2_oper", {29'd0, operator}, 2);
        check_eq("t2_op2",  operand2,          -3);

        // leading zeros, then digit overflow
        press_seq('{4'hF, 4'h0, 4'h0, 4'h5});
        check_eq("t3_five", fnd_serial, 5);
        for (int i = 0; i < 10; i++) press(1'b1, 4'h9);
`ifdef ENTRY_OVF_ERR_EN
        check_eq("t3_err", {31'd0, entry_err}, 1);
        check_eq("t3_fnd", fnd_serial,         32'h8000_0000);
`else
        check_eq("t3_err", {31'd0, entry_err}, 0);
        check_eq("t3_fnd", fnd_serial,         599999999);
`endif
        press(1'b1, 4'hF);
        check_eq("t3_clr_err", {31'd0, entry_err}, 0);
        check_eq("t3_clr_fnd", fnd_serial,         0);

        // chaining: 12*14 = 168, then / 2 =
        press_seq('{4'h1, 4'h2, 4'hC, 4'h1, 4'h4, 4'hE, 4'hD, 4'h2, 4'hE});
        check_eq("t4_op1",  operand1,          168);
        check_eq("t4_oper", {29'd0, operator}, 3);
        check_eq("t4_op2",  operand2,          2);

        // operator replacement in S_OPR, '=' ignored there
        press_seq('{4'hF, 4'h5, 4'hA, 4'hA, 4'hC, 4'hE});
        check_eq("t6_oper",  {29'd0, operator},   2);
        check_eq("t6_start", {31'd0, calc_start}, 0);
        check_eq("t6_fnd",   fnd_serial,          5);

        // reset asserted during the calc_start cycle
        press_seq('{4'h2, 4'hE});
        check_eq("t5_start_pre", {31'd0, calc_start}, 1);
        rst = 1'b0;
        #1;
        check_eq("t5_start", {31'd0, calc_start}, 0);
        check_eq("t5_op1",   operand1,            0);
        check_eq("t5_op2",   operand2,            0);
        check_eq("t5_fnd",   fnd_serial,          0);
        model_reset();
        @(posedge sw_clk); #1;
        rst = 1'b1;
        press_seq('{4'hB, 4'h7});
        check_eq("t5_op1_state", fnd_serial, -7);

        // random presses, including idle cycles carrying junk codes
        press(1'b1, 4'hF);
        for (int n = 0; n < 3000; n++) begin
            int r;
            logic [3:0] k;
            r = $urandom_range(0, 99);
            if (r < 3)       k = 4'hF;
            else if (r < 60) k = 4'($urandom_range(0, 9));
            else             k = 4'($urandom_range(10, 14));
            press($urandom_range(0, 9) < 7, k);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
